// File: rtl/ifu_axi_fetch.sv
// Instruction fetch stage: takes a PC from pcu, performs a single-beat AXI4 read,
// and hands the instruction (with fault status) to idu; flushes drain any in-flight beat.
module ifu_axi_fetch #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int AXI_ID = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              pc_valid_i,
    output logic              pc_ready_o,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              flush_i,
    output logic              arvalid_o,
    input  logic              arready_i,
    output logic [ADDR_W-1:0] araddr_o,
    output logic [ID_W-1:0]   arid_o,
    output logic [7:0]        arlen_o,
    output logic [2:0]        arsize_o,
    output logic [1:0]        arburst_o,
    input  logic              rvalid_i,
    output logic              rready_o,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        rresp_i,
    input  logic              rlast_i,
    input  logic [ID_W-1:0]   rid_i,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic [1:0]        fault_o
);

    localparam logic [1:0] FAULT_OK       = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_BUS      = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        HOLD,
        DRAIN_A,
        DRAIN_R
    } state_t;

    state_t              state_q, state_d;
    logic                arvalid_q, arvalid_d;
    logic [ADDR_W-1:0]   araddr_q, araddr_d;
    logic                inst_valid_q, inst_valid_d;
    logic [DATA_W-1:0]   inst_q, inst_d;
    logic [ADDR_W-1:0]   inst_pc_q, inst_pc_d;
    logic [1:0]          fault_q, fault_d;
    logic                pc_fire;

    // Only one read is ever outstanding, so the returned ID carries no information.
    logic unused_rid;
    assign unused_rid = ^rid_i;

    assign arid_o    = ID_W'(AXI_ID);
    assign arlen_o   = 8'd0;
    assign arsize_o  = 3'b010;
    assign arburst_o = 2'b01;

    assign pc_ready_o   = (state_q == IDLE) && !flush_i && !rst_i;
    assign rready_o     = ((state_q == DATA) || (state_q == DRAIN_R)) && !rst_i;
    assign pc_fire      = pc_valid_i && pc_ready_o;

    assign arvalid_o    = arvalid_q;
    assign araddr_o     = araddr_q;
    assign inst_valid_o = inst_valid_q;
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;
    assign fault_o      = fault_q;

    always_comb begin
        state_d      = state_q;
        arvalid_d    = arvalid_q;
        araddr_d     = araddr_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        fault_d      = fault_q;
        unique case (state_q)
            IDLE: begin
                if (pc_fire) begin
                    inst_pc_d = pc_i;
                    if (pc_i[1:0] != 2'b00) begin
                        // Misaligned PCs never touch the bus; report the fault directly.
                        inst_d       = '0;
                        fault_d      = FAULT_MISALIGN;
                        inst_valid_d = 1'b1;
                        state_d      = HOLD;
                    end else begin
                        araddr_d  = pc_i;
                        arvalid_d = 1'b1;
                        state_d   = ADDR;
                    end
                end
            end
            ADDR: begin
                if (arready_i) begin
                    arvalid_d = 1'b0;
                    state_d   = flush_i ? DRAIN_R : DATA;
                end else if (flush_i) begin
                    state_d = DRAIN_A;
                end
            end
            DATA: begin
                if (rvalid_i) begin
                    if (flush_i) begin
                        state_d = IDLE;
                    end else begin
                        inst_d       = rdata_i;
                        fault_d      = rresp_i[1] ? FAULT_BUS : FAULT_OK;
                        inst_valid_d = 1'b1;
                        state_d      = HOLD;
                    end
                end else if (flush_i) begin
                    state_d = DRAIN_R;
                end
            end
            HOLD: begin
                if (flush_i || inst_ready_i) begin
                    inst_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            DRAIN_A: begin
                // An issued AR cannot be withdrawn; finish it, then swallow its beat.
                if (arready_i) begin
                    arvalid_d = 1'b0;
                    state_d   = DRAIN_R;
                end
            end
            DRAIN_R: begin
                if (rvalid_i && rlast_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            arvalid_q    <= 1'b0;
            araddr_q     <= '0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            fault_q      <= FAULT_OK;
        end else begin
            state_q      <= state_d;
            arvalid_q    <= arvalid_d;
            araddr_q     <= araddr_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            fault_q      <= fault_d;
        end
    end

endmodule

// File: tb/tb_ifu_axi_fetch.sv
// Self-checking bench for ifu_axi_fetch: directed scenarios followed by randomized
// fetches and flushes, with expected results derived from the fetch protocol rules.
module tb_ifu_axi_fetch;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              pc_valid_i;
    logic              pc_ready_o;
    logic [ADDR_W-1:0] pc_i;
    logic              flush_i;
    logic              arvalid_o;
    logic              arready_i;
    logic [ADDR_W-1:0] araddr_o;
    logic [ID_W-1:0]   arid_o;
    logic [7:0]        arlen_o;
    logic [2:0]        arsize_o;
    logic [1:0]        arburst_o;
    logic              rvalid_i;
    logic              rready_o;
    logic [DATA_W-1:0] rdata_i;
    logic [1:0]        rresp_i;
    logic              rlast_i;
    logic [ID_W-1:0]   rid_i;
    logic              inst_valid_o;
    logic              inst_ready_i;
    logic [DATA_W-1:0] inst_o;
    logic [ADDR_W-1:0] inst_pc_o;
    logic [1:0]        fault_o;

    int n_checks = 0;
    int n_fails  = 0;
    int dlv_seen = 0;
    int dlv_exp  = 0;
    int ar_seen  = 0;
    int ar_exp   = 0;

    ifu_axi_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .AXI_ID(0)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .pc_valid_i(pc_valid_i), .pc_ready_o(pc_ready_o), .pc_i(pc_i), .flush_i(flush_i),
        .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o), .arid_o(arid_o),
        .arlen_o(arlen_o), .arsize_o(arsize_o), .arburst_o(arburst_o),
        .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i), .rresp_i(rresp_i),
        .rlast_i(rlast_i), .rid_i(rid_i),
        .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i), .inst_o(inst_o),
        .inst_pc_o(inst_pc_o), .fault_o(fault_o)
    );

    always #5 clk_i = ~clk_i;

    // Handshake counters: delivered instructions and accepted AR requests.
    always @(posedge clk_i) begin
        if (!rst_i) begin
            if (inst_valid_o && inst_ready_i && !flush_i) dlv_seen++;
            if (arvalid_o && arready_i) ar_seen++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic clear_inputs();
        pc_valid_i   = 1'b0;
        pc_i         = $urandom;
        flush_i      = 1'b0;
        arready_i    = 1'b0;
        rvalid_i     = 1'b0;
        rdata_i      = $urandom;
        rresp_i      = 2'b00;
        rlast_i      = 1'b0;
        rid_i        = '0;
        inst_ready_i = 1'b0;
    endtask

    task automatic accept_pc(input logic [31:0] pc);
        pc_valid_i = 1'b1;
        pc_i       = pc;
        #1;
        chk("pc_ready_idle", pc_ready_o, 1'b1);
        step();
        pc_valid_i = 1'b0;
        pc_i       = $urandom;
    endtask

    task automatic hold_phase(input logic [31:0] pc, input logic [31:0] data,
                              input logic [1:0] fault, input int rdy_dly, input bit kill);
        for (int i = 0; i < rdy_dly; i++) begin
            #1;
            chk("hold_valid", inst_valid_o, 1'b1);
            chk("hold_inst", inst_o, data);
            step();
        end
        inst_ready_i = kill ? 1'($urandom) : 1'b1;
        flush_i      = kill;
        #1;
        chk("inst_valid", inst_valid_o, 1'b1);
        chk("inst_data", inst_o, data);
        chk("inst_pc", inst_pc_o, pc);
        chk("inst_fault", fault_o, fault);
        if (!kill) dlv_exp++;
        step();
        inst_ready_i = 1'b0;
        flush_i      = 1'b0;
        #1;
        chk("after_hold_valid", inst_valid_o, 1'b0);
        chk("after_hold_pc_ready", pc_ready_o, 1'b1);
    endtask

    task automatic fetch(input logic [31:0] pc, input int ar_dly, input int r_dly,
                         input logic [31:0] data, input logic [1:0] resp,
                         input int rdy_dly, input bit kill);
        accept_pc(pc);
        if (pc[1:0] != 2'b00) begin
            chk("misalign_no_ar", arvalid_o, 1'b0);
            hold_phase(pc, 32'h0, 2'b01, rdy_dly, kill);
        end else begin
            ar_exp++;
            for (int i = 0; i < ar_dly; i++) begin
                chk("ar_valid_wait", arvalid_o, 1'b1);
                chk("ar_addr_wait", araddr_o, pc);
                step();
            end
            arready_i = 1'b1;
            #1;
            chk("ar_valid", arvalid_o, 1'b1);
            chk("ar_addr", araddr_o, pc);
            step();
            arready_i = 1'b0;
            for (int i = 0; i < r_dly; i++) begin
                #1;
                chk("r_ready_wait", rready_o, 1'b1);
                chk("no_inst_yet", inst_valid_o, 1'b0);
                step();
            end
            rvalid_i = 1'b1;
            rdata_i  = data;
            rresp_i  = resp;
            rlast_i  = 1'b1;
            #1;
            chk("r_ready", rready_o, 1'b1);
            step();
            rvalid_i = 1'b0;
            rlast_i  = 1'b0;
            rdata_i  = $urandom;
            hold_phase(pc, data, resp[1] ? 2'b10 : 2'b00, rdy_dly, kill);
        end
    endtask

    task automatic drain_r(input int r_dly);
        for (int i = 0; i < r_dly; i++) begin
            #1;
            chk("drain_rready", rready_o, 1'b1);
            chk("drain_no_inst", inst_valid_o, 1'b0);
            step();
        end
        rvalid_i = 1'b1;
        rlast_i  = 1'b1;
        rdata_i  = $urandom;
        #1;
        chk("drain_rready_beat", rready_o, 1'b1);
        step();
        rvalid_i = 1'b0;
        rlast_i  = 1'b0;
        #1;
        chk("flush_no_inst", inst_valid_o, 1'b0);
        chk("flush_pc_ready", pc_ready_o, 1'b1);
    endtask

    // where: 0 flush in ADDR w/o arready, 1 flush with arready,
    //        2 flush in DATA w/o rvalid, 3 flush with rvalid.
    task automatic flush_fetch(input logic [31:0] pc, input int where,
                               input int ar_dly, input int r_dly);
        accept_pc(pc);
        ar_exp++;
        case (where)
            0: begin
                flush_i = 1'b1;
                #1;
                chk("flush_pc_ready_low", pc_ready_o, 1'b0);
                step();
                flush_i = 1'b0;
                for (int i = 0; i < ar_dly; i++) begin
                    chk("drain_a_valid", arvalid_o, 1'b1);
                    chk("drain_a_addr", araddr_o, pc);
                    flush_i = 1'($urandom);
                    step();
                    flush_i = 1'b0;
                end
                chk("drain_a_valid_hs", arvalid_o, 1'b1);
                arready_i = 1'b1;
                step();
                arready_i = 1'b0;
                chk("drain_a_dropped", arvalid_o, 1'b0);
                drain_r(r_dly);
            end
            1: begin
                flush_i   = 1'b1;
                arready_i = 1'b1;
                step();
                flush_i   = 1'b0;
                arready_i = 1'b0;
                chk("flush_hs_ar_low", arvalid_o, 1'b0);
                drain_r(r_dly);
            end
            2: begin
                arready_i = 1'b1;
                step();
                arready_i = 1'b0;
                flush_i   = 1'b1;
                step();
                flush_i   = 1'b0;
                drain_r(r_dly);
            end
            default: begin
                arready_i = 1'b1;
                step();
                arready_i = 1'b0;
                flush_i   = 1'b1;
                rvalid_i  = 1'b1;
                rlast_i   = 1'b1;
                #1;
                chk("flush_beat_rready", rready_o, 1'b1);
                step();
                flush_i  = 1'b0;
                rvalid_i = 1'b0;
                rlast_i  = 1'b0;
                #1;
                chk("flush_beat_no_inst", inst_valid_o, 1'b0);
                chk("flush_beat_pc_ready", pc_ready_o, 1'b1);
            end
        endcase
    endtask

    initial begin
        logic [31:0] rpc;
        clear_inputs();
        rst_i      = 1'b1;
        pc_valid_i = 1'b1;
        @(negedge clk_i);
        #1;
        chk("rst_pc_ready", pc_ready_o, 1'b0);
        chk("rst_rready", rready_o, 1'b0);
        chk("rst_arvalid", arvalid_o, 1'b0);
        chk("rst_araddr", araddr_o, 32'h0);
        chk("rst_inst_valid", inst_valid_o, 1'b0);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_inst_pc", inst_pc_o, 32'h0);
        chk("rst_fault", fault_o, 2'b00);
        chk("ar_consts", {arid_o, arlen_o, arsize_o, arburst_o}, {4'h0, 8'h00, 3'b010, 2'b01});
        pc_valid_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        step();

        fetch(32'h8000_0000, 0, 0, 32'h0000_0413, 2'b00, 0, 1'b0);
        fetch(32'h8000_0010, 3, 0, 32'h1234_5678, 2'b00, 5, 1'b0);
        fetch(32'h8000_0020, 0, 1, 32'hDEAD_BEEF, 2'b10, 0, 1'b0);
        fetch(32'h8000_0002, 0, 0, 32'h0, 2'b00, 1, 1'b0);
        flush_fetch(32'h8000_0030, 0, 2, 1);
        flush_fetch(32'h8000_0034, 1, 0, 0);
        flush_fetch(32'h8000_0038, 2, 0, 2);
        flush_fetch(32'h8000_003C, 3, 0, 0);
        fetch(32'h8000_0040, 0, 0, 32'hCAFE_0001, 2'b00, 2, 1'b1);

        // Asynchronous reset while waiting for the R beat.
        accept_pc(32'h8000_0050);
        ar_exp++;
        arready_i = 1'b1;
        step();
        arready_i  = 1'b0;
        pc_valid_i = 1'b1;
        #2;
        rst_i = 1'b1;
        #1;
        chk("arst_rready", rready_o, 1'b0);
        chk("arst_pc_ready", pc_ready_o, 1'b0);
        chk("arst_arvalid", arvalid_o, 1'b0);
        chk("arst_araddr", araddr_o, 32'h0);
        chk("arst_inst_pc", inst_pc_o, 32'h0);
        chk("arst_fault", fault_o, 2'b00);
        pc_valid_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        fetch(32'h8000_0004, 1, 1, 32'h0051_0113, 2'b00, 0, 1'b0);

        for (int t = 0; t < 60; t++) begin
            rpc = $urandom;
            if (($urandom % 4) != 0) rpc[1:0] = 2'b00;
            if (($urandom % 3) != 0) begin
                fetch(rpc, int'($urandom % 4), int'($urandom % 4), $urandom,
                      2'($urandom), int'($urandom % 4), ($urandom % 5) == 0);
            end else begin
                rpc[1:0] = 2'b00;
                flush_fetch(rpc, int'($urandom % 4), int'($urandom % 3), int'($urandom % 3));
            end
        end

        step();
        chk("delivered_count", 64'(dlv_seen), 64'(dlv_exp));
        chk("ar_count", 64'(ar_seen), 64'(ar_exp));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
